sram_serial_host: RTL
=====================

Name: sram_serial_host

Overview:
Host-side initiator for the chip's serial SRAM load/readback port. It converts parallel write and read commands into the pin sequence the chip expects on SRAMSEL, SRAMA, SRAMMUX, SRAMCEN, SRAMWEN, SRAMDIN and SRAMDOUT. It lives on the test/loader FPGA and drives the BNN chip pins directly. It is used to preload INST/DATA SRAM before a run and to read results back while the core is paused.

Parameters:
ADDR_WIDTH, 13, pad address width (INST uses [10:0]).
DATA_WIDTH, 32, DATA SRAM word width (SRAMMUX=1).
INST_WIDTH, 16, INST SRAM word width (SRAMMUX=0).
READ_LAT, 1, idle cycles between the read strobe and the first serial bit being sampled.

Ports:
CLK  in  1  system clock, the same clock that feeds the chip's CLK pin.
RST  in  1  asynchronous active-low reset.
CMD_VALID  in  1  command request.
CMD_READY  out  1  command accepted when VALID&READY.
CMD_WRITE  in  1  1=write, 0=read.
CMD_MUX  in  1  1=DATA SRAM, 0=INST SRAM.
CMD_ADDR  in  ADDR_WIDTH  SRAM address.
CMD_WDATA  in  DATA_WIDTH  write word; only [15:0] is used when MUX=0.
RSP_VALID  out  1  one-cycle pulse; RSP_RDATA is valid.
RSP_RDATA  out  DATA_WIDTH  read word, zero-extended for INST.
BUSY  out  1  high when the FSM is not in IDLE.
SRAMSEL  out  1  pad: host owns the SRAMs.
SRAMA  out  ADDR_WIDTH  pad address.
SRAMMUX  out  1  pad select.
SRAMCEN  out  1  pad chip-enable, active low.
SRAMWEN  out  1  pad write-enable, active low.
SRAMDIN  out  1  pad serial data to the chip.
SRAMDOUT  in  1  pad serial data from the chip.

Behaviour:
- Reset (RST=0, async) sets:
  - SRAMSEL=0, SRAMCEN=1, SRAMWEN=1, SRAMDIN=0, SRAMA=0, SRAMMUX=0.
  - CMD_READY=0, RSP_VALID=0, RSP_RDATA=0, BUSY=0.
  - FSM goes to IDLE.
- All pad outputs are registered. No combinational path exists from any input to any pad.
- Word length: N = CMD_MUX ? DATA_WIDTH : INST_WIDTH. The value is latched at command accept.
- FSM states: IDLE, W_SHIFT, W_COMMIT, R_STROBE, R_WAIT, R_SHIFT, R_DONE.
- IDLE:
  - CMD_READY=1 and SRAMSEL=0.
  - On VALID&READY, latch MUX, ADDR, WDATA and WRITE, and drive SRAMSEL=1, SRAMA and SRAMMUX.
  - These pad values stay stable until the FSM returns to IDLE.
  - Next state is W_SHIFT if WRITE, otherwise R_STROBE.
- W_SHIFT:
  - N cycles with SRAMCEN=1, SRAMWEN=1 (this opens the chip shift enable).
  - SRAMDIN carries WDATA MSB first: bit N-1 in the first cycle, bit 0 in the last.
  - A bit counter counts N-1 down to 0.
- W_COMMIT:
  - One cycle with SRAMCEN=0, SRAMWEN=0 and SRAMDIN=0. The chip writes its assembled word.
  - Next state is IDLE.
- R_STROBE:
  - One cycle with SRAMCEN=0, SRAMWEN=1. The chip reads SRAM and loads its parallel-to-serial register.
- R_WAIT:
  - READ_LAT cycles with SRAMCEN=1, SRAMWEN=1.
  - Skipped when READ_LAT=0.
- R_SHIFT:
  - N cycles with SRAMCEN=1, SRAMWEN=1.
  - SRAMDOUT is sampled each cycle into a shift register (shift left, new bit into LSB), giving MSB-first reconstruction.
- R_DONE:
  - One cycle with RSP_VALID=1 and RSP_RDATA = the assembled word, zero-extended to DATA_WIDTH.
  - Next state is IDLE.
  - RSP_RDATA holds its value until the next read completes.
- Latency:
  - Write: 1 (accept) + N + 1 cycles until CMD_READY returns.
  - Read: 1 + 1 + READ_LAT + N + 1 cycles.
- Boundaries:
  - CMD_VALID while BUSY is ignored (READY=0). There is no queue.
  - Address wrap is the caller's responsibility. ADDR passes through unchanged.
  - For INST, SRAMA[12:11] are driven as latched and are don't-care at the chip.
  - Back-to-back commands give one IDLE cycle between commands, with SRAMSEL=0 in that cycle.
  - Reset mid-command aborts immediately. Pads return to reset values and no RSP_VALID is produced.
  - A partial write is never committed, because the commit cycle is never reached.
- SRAMDIN is 0 in every state other than W_SHIFT.

Decomposition:
- Shared package bnn_host_pkg holds:
  - the FSM state enum;
  - the constants DATA_WIDTH=32, INST_WIDTH=16, ADDR_WIDTH=13;
  - CEN/WEN encodings (SHIFT=2'b11, WRITE=2'b00, READ=2'b01).
- One natural sub-module, host_shift_reg. It is a bidirectional DATA_WIDTH shifter with load, shift-out MSB, shift-in LSB, and a length select of 16 or 32.

Test Plan:
1. Reset release, no command -> SRAMSEL=0, CEN=WEN=1, READY=1, BUSY=0.
2. Write MUX=1, ADDR=0x0123, WDATA=0xA5A5_00FF -> SRAMDIN is 1,0,1,0,0,1,0,1,... over 32 cycles. Then one cycle of CEN=WEN=0 at SRAMA=0x0123. A chip model's DATA SRAM[0x123]=0xA5A500FF. READY returns after 34 cycles.
3. Write MUX=0, ADDR=0x07FF, WDATA=0xFFFF_1234 -> exactly 16 shift cycles carrying 0x1234. INST[0x7FF]=0x1234.
4. Read MUX=1, ADDR=0x0123 with the chip model after scenario 2 -> strobe cycle with CEN=0, WEN=1, then READ_LAT wait, then 32 samples. RSP_VALID pulses once with RSP_RDATA=0xA5A500FF.
5. Read MUX=0, ADDR=0x07FF -> RSP_RDATA=0x0000_1234. CMD_VALID held high during the read is not accepted until IDLE.
6. RST=0 asserted at bit 10 of a DATA write to 0x0040 (pre-content 0xDEADBEEF) -> pads return to reset values asynchronously. No commit occurs, a subsequent read returns 0xDEADBEEF, and no RSP_VALID appears during the abort.

Source files
------------

// File: rtl/bnn_host_pkg.sv
// Shared types and constants for the serial SRAM host initiator.
package bnn_host_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned INST_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 13;

    // {SRAMCEN, SRAMWEN} pad encodings
    localparam logic [1:0] CW_SHIFT = 2'b11;
    localparam logic [1:0] CW_WRITE = 2'b00;
    localparam logic [1:0] CW_READ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SHIFT  = 3'd1,
        ST_W_COMMIT = 3'd2,
        ST_R_STROBE = 3'd3,
        ST_R_WAIT   = 3'd4,
        ST_R_SHIFT  = 3'd5,
        ST_R_DONE   = 3'd6
    } host_state_e;

endpackage

// File: rtl/host_shift_reg.sv
// Bidirectional shifter: shifts out at the selected-length MSB, shifts in at the LSB.
module host_shift_reg #(
    parameter int unsigned DATA_WIDTH = bnn_host_pkg::DATA_WIDTH,
    parameter int unsigned INST_WIDTH = bnn_host_pkg::INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  shift_i,
    input  logic                  shift_in_i,
    input  logic                  len32_i,
    output logic                  msb_c_o,
    output logic [DATA_WIDTH-1:0] word_next_c_o
);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] sr_d;
    logic [DATA_WIDTH-1:0] shifted_c;

    // Load has priority over shift
    always_comb begin
        shifted_c = {sr_q[DATA_WIDTH-2:0], shift_in_i};
        sr_d      = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = shifted_c;
        end
    end

    // Shift register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_c_o       = len32_i ? sr_q[DATA_WIDTH-1] : sr_q[INST_WIDTH-1];
    // Word as it will look after the current shift-in, zero-extended for 16-bit words
    assign word_next_c_o = len32_i ? shifted_c : DATA_WIDTH'(shifted_c[INST_WIDTH-1:0]);

endmodule

// File: rtl/sram_serial_host.sv
// Serial SRAM load/readback initiator driving the BNN chip SRAM pads.
module sram_serial_host
    import bnn_host_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = bnn_host_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = bnn_host_pkg::DATA_WIDTH,
    parameter int unsigned INST_WIDTH = bnn_host_pkg::INST_WIDTH,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic                  cmd_mux_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  busy_o,
    output logic                  sramsel_o,
    output logic [ADDR_WIDTH-1:0] srama_o,
    output logic                  srammux_o,
    output logic                  sramcen_o,
    output logic                  sramwen_o,
    output logic                  sramdin_o,
    input  logic                  sramdout_i
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    host_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  mux_q, mux_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  sel_q, sel_d;
    logic [1:0]            cw_q, cw_d;
    logic                  din_q, din_d;

    logic                  accept_c;
    logic                  sh_load;
    logic [DATA_WIDTH-1:0] sh_load_data;
    logic                  sh_shift;
    logic                  sh_msb_c;
    logic [DATA_WIDTH-1:0] sh_word_next_c;

    assign accept_c = cmd_valid_i & ready_q;

    host_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_shift (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (sh_load),
        .load_data_i   (sh_load_data),
        .shift_i       (sh_shift),
        .shift_in_i    (sramdout_i),
        .len32_i       (mux_q),
        .msb_c_o       (sh_msb_c),
        .word_next_c_o (sh_word_next_c)
    );

    // Next-state, shifter control and registered pad values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        mux_d        = mux_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        din_d        = 1'b0;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        // Preload one position ahead: the first bit leaves via din_d at accept
        sh_load_data = cmd_write_i ? {cmd_wdata_i[DATA_WIDTH-2:0], 1'b0} : '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    mux_d   = cmd_mux_i;
                    addr_d  = cmd_addr_i;
                    cnt_d   = cmd_mux_i ? CNT_W'(DATA_WIDTH - 1) : CNT_W'(INST_WIDTH - 1);
                    sh_load = 1'b1;
                    if (cmd_write_i) begin
                        state_d = ST_W_SHIFT;
                        din_d   = cmd_mux_i ? cmd_wdata_i[DATA_WIDTH-1] : cmd_wdata_i[INST_WIDTH-1];
                    end else begin
                        state_d = ST_R_STROBE;
                    end
                end
            end
            ST_W_SHIFT: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_W_COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    din_d = sh_msb_c;
                end
            end
            ST_W_COMMIT: begin
                state_d = ST_IDLE;
            end
            ST_R_STROBE: begin
                if (READ_LAT == 0) begin
                    state_d = ST_R_SHIFT;
                end else begin
                    state_d = ST_R_WAIT;
                    lat_d   = LAT_W'(READ_LAT - 1);
                end
            end
            ST_R_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_R_SHIFT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_R_SHIFT: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_R_DONE;
                    rdata_d = sh_word_next_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_R_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sel_d       = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_R_DONE);
        if (state_d == ST_W_COMMIT) begin
            cw_d = CW_WRITE;
        end else if (state_d == ST_R_STROBE) begin
            cw_d = CW_READ;
        end else begin
            cw_d = CW_SHIFT;
        end
    end

    // State and pad registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            mux_q       <= 1'b0;
            addr_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            sel_q       <= 1'b0;
            cw_q        <= CW_SHIFT;
            din_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            mux_q       <= mux_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
            cw_q        <= cw_d;
            din_q       <= din_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = busy_q;
    assign sramsel_o   = sel_q;
    assign srama_o     = addr_q;
    assign srammux_o   = mux_q;
    assign sramcen_o   = cw_q[1];
    assign sramwen_o   = cw_q[0];
    assign sramdin_o   = din_q;

endmodule
